// File: rtl/axi_stream_video_pkg.sv
// Shared types and constants for the AXI-Stream video pattern source.
// Pixel, pattern and FSM encodings plus the colour-bar palette.
package axi_stream_video_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    RAMP    = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  localparam pixel_t BAR_COLOURS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/axi_stream_pattern_gen.sv
// Combinational pixel generator: pattern, x, y, bar index, frame tag
// in; one RGB888 pixel out. No state, no arithmetic beyond selection.
module axi_stream_pattern_gen
  import axi_stream_video_pkg::*;
(
  input  pattern_e    pattern,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [2:0]  bar,
  input  logic [7:0]  tag,
  output pixel_t      pixel
);

  logic unused_ok;
  assign unused_ok = ^{y[7:4], y[2:0]};

  always_comb begin
    pixel = '0;
    unique case (pattern)
      BARS:    pixel = BAR_COLOURS[bar];
      RAMP:    pixel = {x, x, x};
      CHECKER: pixel = (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h000000;
      SOLID:   pixel = {tag, 8'h00, 8'hFF};
      default: pixel = '0;
    endcase
  end

endmodule

// File: rtl/axi_stream_pattern_source.sv
// AXI-Stream raster test-pattern master (tuser = SOF, tlast = EOL/EOF).
// Ports: clk/rst_n, enable, pattern_sel, m_axis_*, frame_count, busy.
module axi_stream_pattern_source
  import axi_stream_video_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int TLAST_MODE = 0,
  parameter int FRAME_GAP  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [31:0]           frame_count,
  output logic                  busy
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int GW = $clog2(FRAME_GAP + 2);
  localparam int BAR_W = (H_ACTIVE / 8 > 1) ? H_ACTIVE / 8 : 1;

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [XW-1:0] B_LAST = XW'(BAR_W - 1);
  localparam logic [GW-1:0] G_LAST =
    GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [2:0]      bar_q, bar_d;
  logic [XW-1:0]   bcnt_q, bcnt_d;
  pattern_e        pat_q, pat_d;
  logic [7:0]      tag_q, tag_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [31:0]     fc_d;
  logic            valid_d;
  logic            load;
  logic            start;
  logic            fire;
  logic            x_end;
  logic            y_end;
  logic            last_d;
  logic            user_d;
  pixel_t          pix;

  assign fire  = m_axis_tvalid && m_axis_tready;
  assign x_end = (x_q == X_LAST);
  assign y_end = (y_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    bar_d   = bar_q;
    bcnt_d  = bcnt_q;
    pat_d   = pat_q;
    tag_d   = tag_q;
    gap_d   = gap_q;
    fc_d    = frame_count;
    valid_d = m_axis_tvalid;
    load    = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) start = 1'b1;
      end
      ACTIVE: begin
        if (fire) begin
          if (x_end && y_end) begin
            fc_d = frame_count + 32'd1;
            if (FRAME_GAP > 0) begin
              state_d = GAP;
              gap_d   = '0;
              valid_d = 1'b0;
            end else if (enable) begin
              start = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
            end
          end else begin
            load = 1'b1;
            if (x_end) begin
              x_d    = '0;
              y_d    = y_q + 1'b1;
              bar_d  = '0;
              bcnt_d = '0;
            end else begin
              x_d = x_q + 1'b1;
              // bar index saturates at the last bar
              if (bar_q != 3'd7) begin
                if (bcnt_q == B_LAST) begin
                  bar_d  = bar_q + 3'd1;
                  bcnt_d = '0;
                end else begin
                  bcnt_d = bcnt_q + 1'b1;
                end
              end
            end
          end
        end
      end
      GAP: begin
        if (gap_q == G_LAST) begin
          if (enable) start = 1'b1;
          else state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = ACTIVE;
      x_d     = '0;
      y_d     = '0;
      bar_d   = '0;
      bcnt_d  = '0;
      pat_d   = pattern_e'(pattern_sel);
      // solid pattern carries the count as seen at SOF
      tag_d   = fc_d[7:0];
      valid_d = 1'b1;
      load    = 1'b1;
    end
  end

  assign last_d = (x_d == X_LAST) &&
                  (TLAST_MODE == 0 || y_d == Y_LAST);
  assign user_d = (x_d == '0) && (y_d == '0);

  axi_stream_pattern_gen u_gen (
    .pattern (pat_d),
    .x       (8'(x_d)),
    .y       (8'(y_d)),
    .bar     (bar_d),
    .tag     (tag_d),
    .pixel   (pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      bar_q         <= '0;
      bcnt_q        <= '0;
      pat_q         <= BARS;
      tag_q         <= '0;
      gap_q         <= '0;
      frame_count   <= '0;
      busy          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      bar_q         <= bar_d;
      bcnt_q        <= bcnt_d;
      pat_q         <= pat_d;
      tag_q         <= tag_d;
      gap_q         <= gap_d;
      frame_count   <= fc_d;
      busy          <= (state_d != IDLE);
      m_axis_tvalid <= valid_d;
      if (load) begin
        m_axis_tdata <= DATA_WIDTH'(pix);
        m_axis_tlast <= last_d;
        m_axis_tuser <= user_d;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_pattern_source.sv
// Scoreboard bench for axi_stream_pattern_source over four configs.
// Expected beats come from a raster model; a monitor pops and compares.
module tb_axi_stream_pattern_source;

  localparam int NI = 4;

  int hcfg[NI] = '{4, 4, 16, 8};
  int vcfg[NI] = '{2, 2, 16, 1};
  int mcfg[NI] = '{0, 1, 0, 0};
  int gcfg[NI] = '{0, 0, 0, 3};
  int fcm[NI]  = '{0, 0, 0, 0};

  logic [23:0] bars[8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  psel;
  logic        en[NI];
  logic        tready;
  int          sel;

  logic [23:0] td[NI];
  logic        tv[NI];
  logic        tl[NI];
  logic        tu[NI];
  logic        bz[NI];
  logic [31:0] fc[NI];

  logic [23:0] m_data;
  logic        m_valid, m_last, m_user;

  always #5 clk = ~clk;

  axi_stream_pattern_source #(
    .DATA_WIDTH(24), .H_ACTIVE(4), .V_ACTIVE(2),
    .TLAST_MODE(0), .FRAME_GAP(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .pattern_sel(psel),
    .m_axis_tdata(td[0]), .m_axis_tvalid(tv[0]),
    .m_axis_tlast(tl[0]), .m_axis_tuser(tu[0]),
    .m_axis_tready(tready && (sel == 0)),
    .frame_count(fc[0]), .busy(bz[0])
  );

  axi_stream_pattern_source #(
    .DATA_WIDTH(24), .H_ACTIVE(4), .V_ACTIVE(2),
    .TLAST_MODE(1), .FRAME_GAP(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .pattern_sel(psel),
    .m_axis_tdata(td[1]), .m_axis_tvalid(tv[1]),
    .m_axis_tlast(tl[1]), .m_axis_tuser(tu[1]),
    .m_axis_tready(tready && (sel == 1)),
    .frame_count(fc[1]), .busy(bz[1])
  );

  axi_stream_pattern_source #(
    .DATA_WIDTH(24), .H_ACTIVE(16), .V_ACTIVE(16),
    .TLAST_MODE(0), .FRAME_GAP(0)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .enable(en[2]), .pattern_sel(psel),
    .m_axis_tdata(td[2]), .m_axis_tvalid(tv[2]),
    .m_axis_tlast(tl[2]), .m_axis_tuser(tu[2]),
    .m_axis_tready(tready && (sel == 2)),
    .frame_count(fc[2]), .busy(bz[2])
  );

  axi_stream_pattern_source #(
    .DATA_WIDTH(24), .H_ACTIVE(8), .V_ACTIVE(1),
    .TLAST_MODE(0), .FRAME_GAP(3)
  ) u3 (
    .clk(clk), .rst_n(rst_n), .enable(en[3]), .pattern_sel(psel),
    .m_axis_tdata(td[3]), .m_axis_tvalid(tv[3]),
    .m_axis_tlast(tl[3]), .m_axis_tuser(tu[3]),
    .m_axis_tready(tready && (sel == 3)),
    .frame_count(fc[3]), .busy(bz[3])
  );

  always_comb begin
    m_data  = td[sel];
    m_valid = tv[sel];
    m_last  = tl[sel];
    m_user  = tu[sel];
  end

  typedef struct {
    logic [23:0] d;
    logic        l;
    logic        u;
    int          gap;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    popped = 0;
  int    hs_cnt = 0;
  int    idle   = 1000;
  bit    mon_on = 1'b0;
  bit    rand_ready = 1'b0;

  function automatic logic [23:0] exp_pix(int h, int pat, int x,
                                          int y, int k);
    int bw;
    int idx;
    logic [7:0] xb;
    logic [7:0] kb;
    xb = 8'(x);
    kb = 8'(k);
    case (pat)
      0: begin
        bw = h / 8;
        if (bw < 1) bw = 1;
        idx = x / bw;
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      1: return {xb, xb, xb};
      2: return (((x / 8) + (y / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
      default: return {kb, 8'h00, 8'hFF};
    endcase
  endfunction

  task automatic push_frame(int i, int pat, int k, int g);
    beat_t b;
    for (int y = 0; y < vcfg[i]; y++) begin
      for (int x = 0; x < hcfg[i]; x++) begin
        b.d = exp_pix(hcfg[i], pat, x, y, k);
        if (mcfg[i] == 1)
          b.l = (x == hcfg[i] - 1) && (y == vcfg[i] - 1);
        else
          b.l = (x == hcfg[i] - 1);
        b.u = (x == 0) && (y == 0);
        b.gap = (x == 0 && y == 0) ? g : -1;
        q.push_back(b);
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ready driver: changes just after the edge
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // monitor: a beat seen valid&&ready here transfers on the next edge
  initial begin
    beat_t b;
    logic        pv_v, pv_r, pv_l, pv_u;
    logic [23:0] pv_d;
    pv_v = 1'b0;
    pv_r = 1'b0;
    pv_l = 1'b0;
    pv_u = 1'b0;
    pv_d = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mon_on) begin
        if (pv_v && !pv_r) begin
          checks++;
          if (!(m_valid && m_data == pv_d &&
                m_last == pv_l && m_user == pv_u)) begin
            errors++;
            $display("FAIL hold_stable actual=%0h/%0b/%0b/%0b required=%0h/1/%0b/%0b",
                     m_data, m_valid, m_last, m_user, pv_d, pv_l, pv_u);
          end
        end
        if (m_valid && tready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none",
                     m_data);
          end else begin
            b = q.pop_front();
            popped++;
            if ({m_data, m_last, m_user} !== {b.d, b.l, b.u}) begin
              errors++;
              $display("FAIL beat%0d actual=%0h/l%0b/u%0b required=%0h/l%0b/u%0b",
                       popped, m_data, m_last, m_user, b.d, b.l, b.u);
            end
            if (b.gap >= 0) begin
              checks++;
              if (idle != b.gap) begin
                errors++;
                $display("FAIL frame_gap actual=%0d required=%0d",
                         idle, b.gap);
              end
            end
          end
          idle = 0;
        end else if (!m_valid) begin
          idle++;
        end
        pv_v = m_valid;
        pv_r = tready;
        pv_d = m_data;
        pv_l = m_last;
        pv_u = m_user;
      end else begin
        pv_v = 1'b0;
        idle = 1000;
      end
      if (rst_n && m_valid && tready) hs_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_popped(int n, int budget);
    int c = 0;
    while (popped < n && c < budget) begin
      step();
      c++;
    end
    if (popped < n) begin
      checks++;
      errors++;
      $display("FAIL timeout_beats actual=%0d required=%0d", popped, n);
    end
  endtask

  task automatic wait_empty(int budget);
    int c = 0;
    while (q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_drain actual=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic run(int i, int pat, int nf, int drop, bit rnd);
    int base;
    int fpx;
    sel = i;
    rand_ready = rnd;
    psel = 2'(pat);
    base = popped;
    fpx = hcfg[i] * vcfg[i];
    for (int f = 0; f < nf; f++)
      push_frame(i, pat, fcm[i] + f, (f == 0) ? -1 : gcfg[i]);
    mon_on = 1'b1;
    en[i] = 1'b1;
    wait_popped(base + (nf - 1) * fpx + drop, 5000);
    en[i] = 1'b0;
    psel = 2'(pat + 1);
    wait_empty(20000);
    repeat (12) step();
    fcm[i] += nf;
    chk($sformatf("frame_count_u%0d", i), fc[i], 32'(fcm[i]));
    chk($sformatf("busy_idle_u%0d", i), 32'(bz[i]), 32'd0);
    chk($sformatf("tvalid_idle_u%0d", i), 32'(tv[i]), 32'd0);
    rand_ready = 1'b0;
  endtask

  initial begin
    int base;
    int c;
    rst_n = 1'b0;
    sel = 0;
    psel = 2'd0;
    for (int i = 0; i < NI; i++) en[i] = 1'b0;
    repeat (3) step();
    chk("reset_tvalid", 32'(tv[0]), 32'd0);
    chk("reset_frame_count", fc[0], 32'd0);
    chk("reset_busy", 32'(bz[0]), 32'd0);
    rst_n = 1'b1;
    step();

    run(0, 1, 1, 1, 1'b0);
    run(1, int'($urandom_range(3, 0)), 1, 1, 1'b1);
    run(1, 3, 1, 1, 1'b1);
    run(2, 2, 1, 5, 1'b0);
    run(3, 3, 3, 1, 1'b0);
    run(3, 0, 1, 1, 1'b0);
    run(0, int'($urandom_range(3, 0)), 2, 1, 1'b1);

    // reset in the middle of a frame
    sel = 0;
    mon_on = 1'b0;
    psel = 2'd3;
    en[0] = 1'b1;
    base = hs_cnt;
    c = 0;
    while (hs_cnt < base + 3 && c < 100) begin
      step();
      c++;
    end
    chk("reset_reach_beat3", 32'(hs_cnt >= base + 3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", 32'(tv[0]), 32'd0);
    chk("rst_tdata", 32'(td[0]), 32'd0);
    chk("rst_tlast", 32'(tl[0]), 32'd0);
    chk("rst_tuser", 32'(tu[0]), 32'd0);
    chk("rst_frame_count", fc[0], 32'd0);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    repeat (3) step();
    chk("rst_hold_tvalid", 32'(tv[0]), 32'd0);
    for (int i = 0; i < NI; i++) fcm[i] = 0;
    rst_n = 1'b1;
    run(0, 3, 1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
